// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and constants for the wheel motor path (speed ramp, MotorDriver,
// bluetooth_wrapper).
//   MOTOR_SPEED_W : default width of a signed wheel speed
//   SPEED_MAX     : largest representable forward speed magnitude
//   speed_t       : signed wheel speed
//   ramp_state_e  : speed ramp controller states
//   cnt_width()   : bit width needed for a counter holding 0..n
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam int MOTOR_SPEED_W = 10;
    localparam int SPEED_MAX     = (1 << (MOTOR_SPEED_W - 1)) - 1;

    typedef logic signed [MOTOR_SPEED_W-1:0] speed_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        STOPPING
    } ramp_state_e;

    // Never returns 0 so a degenerate counter still has a legal declaration.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle update tick every TICK_DIV clocks.
// The count runs 0..TICK_DIV-1 and tick is high while the count sits at
// TICK_DIV-1, after which it wraps to 0.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; count returns to 0
//   tick  : one-cycle strobe, once per TICK_DIV cycles
// ---------------------------------------------------------------------------
module tick_prescaler
    import motor_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int              CW   = cnt_width(TICK_DIV - 1);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/motor_speed_ramp.sv
// ---------------------------------------------------------------------------
// motor_speed_ramp
// Acceleration-limited command stage feeding one MotorDriver. Slews a signed
// current speed toward the setpoint by at most ACCEL_STEP per update tick, and
// forces stop -> direction settle -> restart whenever the direction reverses,
// so the stepper never sees a speed jump or a live direction flip.
//
// Ports
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   cmd_valid : one-cycle strobe, cmd_speed is a new setpoint
//   cmd_speed : signed setpoint, sign = direction (+ = forward)
//   run_req   : 1 = motor enabled, 0 = controlled stop then disable
//   speed_out : |current speed| to MotorDriver.speed (never negative)
//   dir_out   : 1 = forward, 0 = reverse, to MotorDriver.dir_in
//   motor_on  : to MotorDriver.run_en
//   at_target : current speed equals the effective target while running
//   timeout   : watchdog fired, sticky until the next cmd_valid
//
// Build option
//   MOTOR_RAMP_WATCHDOG_EN : when defined, a tick counter cleared by each
//   cmd_valid forces the target to 0 after TIMEOUT_TICKS ticks without a new
//   command and raises timeout. When undefined the target is held forever and
//   timeout is tied low.
// ---------------------------------------------------------------------------
module motor_speed_ramp
    import motor_pkg::*;
#(
    parameter int SPEED_W       = MOTOR_SPEED_W,
    parameter int TICK_DIV      = 100000,
    parameter int ACCEL_STEP    = 4,
    parameter int DIR_SETTLE    = 2,
    parameter int TIMEOUT_TICKS = 500
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic signed [SPEED_W-1:0] cmd_speed,
    input  logic                      run_req,
    output logic signed [SPEED_W-1:0] speed_out,
    output logic                      dir_out,
    output logic                      motor_on,
    output logic                      at_target,
    output logic                      timeout
);

    localparam int MSB = SPEED_W - 1;
    localparam int XW  = SPEED_W + 2;

    // Settle and watchdog counters share one width.
    localparam int CNT_W = cnt_width((DIR_SETTLE > TIMEOUT_TICKS) ? DIR_SETTLE : TIMEOUT_TICKS);

    localparam logic signed [XW-1:0]      STEP_X      = XW'(ACCEL_STEP);
    localparam logic signed [SPEED_W-1:0] STEP_S      = SPEED_W'(ACCEL_STEP);
    localparam logic signed [SPEED_W-1:0] NEG_FULL    = {1'b1, {(SPEED_W - 1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] NEG_SAT     = {1'b1, {(SPEED_W - 2){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]          SETTLE_LOAD = CNT_W'(DIR_SETTLE);

    logic tick;

    ramp_state_e               state_q, state_d;
    logic signed [SPEED_W-1:0] cur_q, cur_d;
    logic signed [SPEED_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]          settle_q, settle_d;
    logic                      dir_q, dir_d;

    logic signed [SPEED_W-1:0] speed_out_q, speed_out_d;
    logic                      dir_out_q, dir_out_d;
    logic                      motor_on_q, motor_on_d;
    logic                      at_target_q, at_target_d;

    logic signed [SPEED_W-1:0] eff_target;
    logic signed [SPEED_W-1:0] slew_goal;
    logic signed [SPEED_W-1:0] slew_next;
    logic signed [XW-1:0]      slew_diff;
    logic signed [SPEED_W-1:0] cmd_sat;

`ifdef MOTOR_RAMP_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [CNT_W-1:0] wd_q, wd_d;
    logic             timeout_q, timeout_d;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Slew goal: head for zero when stopping, when there is no target, when
    // the current speed points the wrong way, or when standing still with a
    // target whose direction does not match dir_q (a settle must come first).
    // Otherwise head for the target. The step is clamped so it lands exactly
    // on the goal instead of overshooting it.
    always_comb begin
        eff_target = run_req ? target_q : '0;
        if (state_q == STOPPING || eff_target == '0 ||
            (cur_q != '0 && cur_q[MSB] != eff_target[MSB]) ||
            (cur_q == '0 && eff_target[MSB] == dir_q)) begin
            slew_goal = '0;
        end else begin
            slew_goal = eff_target;
        end
        slew_diff = {{2{slew_goal[MSB]}}, slew_goal} - {{2{cur_q[MSB]}}, cur_q};
        if (slew_diff > STEP_X) begin
            slew_next = cur_q + STEP_S;
        end else if (slew_diff < -STEP_X) begin
            slew_next = cur_q - STEP_S;
        end else begin
            slew_next = slew_goal;
        end
    end

    // Controller FSM. Direction is only ever changed on entry to SETTLE, and
    // every path into SETTLE requires the current speed to already be 0.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        settle_d = settle_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (run_req && target_q != '0) begin
                    state_d  = SETTLE;
                    dir_d    = ~target_q[MSB];
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (!run_req) begin
                    state_d = IDLE;
                end else if (tick) begin
                    settle_d = settle_q - CNT_W'(1);
                    if (settle_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    cur_d = slew_next;
                end
                if (!run_req) begin
                    state_d = STOPPING;
                end else if (cur_q == '0 && target_q != '0 && target_q[MSB] == dir_q) begin
                    state_d  = SETTLE;
                    dir_d    = ~dir_q;
                    settle_d = SETTLE_LOAD;
                end
            end
            STOPPING: begin
                if (tick) begin
                    cur_d = slew_next;
                end
                if (cur_q == '0) begin
                    if (run_req && target_q != '0) begin
                        state_d  = SETTLE;
                        dir_d    = ~target_q[MSB];
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Setpoint capture. The most negative code has no positive twin, so it is
    // pulled in by one to keep |speed| representable. The optional watchdog
    // drops the target to 0 after a run of ticks with no fresh command.
    always_comb begin
        cmd_sat  = (cmd_speed == NEG_FULL) ? NEG_SAT : cmd_speed;
        target_d = cmd_valid ? cmd_sat : target_q;
`ifdef MOTOR_RAMP_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (cmd_valid) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end else if (tick && wd_q != WD_LIMIT) begin
            wd_d = wd_q + CNT_W'(1);
            if (wd_d == WD_LIMIT) begin
                target_d  = '0;
                timeout_d = 1'b1;
            end
        end
`endif
    end

    // Outputs are a registered view of the controller, one cycle behind it.
    always_comb begin
        speed_out_d = cur_q[MSB] ? -cur_q : cur_q;
        dir_out_d   = dir_q;
        motor_on_d  = (state_q != IDLE);
        at_target_d = (state_q == RUN) && (cur_q == eff_target);
    end

    // A reset mid-ramp releases the motor at once; there is no ramp-down.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            target_q    <= '0;
            settle_q    <= '0;
            dir_q       <= 1'b1;
            speed_out_q <= '0;
            dir_out_q   <= 1'b1;
            motor_on_q  <= 1'b0;
            at_target_q <= 1'b0;
`ifdef MOTOR_RAMP_WATCHDOG_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            settle_q    <= settle_d;
            dir_q       <= dir_d;
            speed_out_q <= speed_out_d;
            dir_out_q   <= dir_out_d;
            motor_on_q  <= motor_on_d;
            at_target_q <= at_target_d;
`ifdef MOTOR_RAMP_WATCHDOG_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign speed_out = speed_out_q;
    assign dir_out   = dir_out_q;
    assign motor_on  = motor_on_q;
    assign at_target = at_target_q;
`ifdef MOTOR_RAMP_WATCHDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
